imem_dmem_port_arbiter: RTL and testbench

Shares one single-ported memory between the instruction fetch path and the load/store unit. Fetch requests are read-only; LSU requests may be reads or byte-enabled writes. The block arbitrates issue, holds the chosen request stable until the memory accepts it, and tracks outstanding transactions in order so each response returns to its owner. It sits between the fetch unit/LSU and the memory interface.

---
 rtl/imem_dmem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU: arbitrates issue,
// locks the chosen request until the memory accepts it, and routes in-order responses back.
module imem_dmem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [DATA_W/8-1:0]   ls_be_i,
  input  logic [ADDR_W-1:0]     ls_addr_i,
  input  logic [DATA_W-1:0]     ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_W-1:0]     ls_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 3;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [1:0]       PTR_LAST = 2'(MAX_OUTSTANDING - 1);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, HOLD_IF, HOLD_LS} state_t;

  state_t            state;
  state_t            state_next;
  logic              sel_valid;
  logic              sel_ls;
  logic              hold_drop;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              head;
  logic [CNT_W-1:0]  count;
  logic [1:0]        rd_ptr;
  logic [1:0]        wr_ptr;
  logic [3:0]        owner_q;
  logic [SC_W-1:0]   starve_cnt;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign full   = (count == CNT_MAX);
  assign empty  = (count == '0);
  assign head   = owner_q[rd_ptr];
  assign accept = mem_req_o && mem_gnt_i;
  assign push   = accept;
  assign pop    = mem_rvalid_i && !empty;

  // While a HOLD state is active the selection is pinned to that requester.
  always_comb begin
    sel_valid = 1'b0;
    sel_ls    = 1'b0;
    hold_drop = 1'b0;
    unique case (state)
      HOLD_IF: begin
        sel_valid = if_req_i;
        hold_drop = !if_req_i;
      end
      HOLD_LS: begin
        sel_valid = ls_req_i;
        sel_ls    = 1'b1;
        hold_drop = !ls_req_i;
      end
      default: begin
        sel_valid = if_req_i || ls_req_i;
        sel_ls    = ls_req_i && !(if_req_i && starve_cnt == SC_MAX);
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (sel_valid && !accept) begin
          state_next = sel_ls ? HOLD_LS : HOLD_IF;
        end
      end
      default: begin
        if (accept || hold_drop) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // mem_req is gated by reset so nothing is issued while reset is held.
  always_comb begin
    mem_req_o   = reset_n && sel_valid && !full;
    mem_we_o    = sel_ls && ls_we_i;
    mem_be_o    = sel_ls ? ls_be_i : {BE_W{1'b1}};
    mem_addr_o  = sel_ls ? ls_addr_i : if_addr_i;
    mem_wdata_o = sel_ls ? ls_wdata_i : '0;
    if_gnt_o    = mem_req_o && mem_gnt_i && !sel_ls;
    ls_gnt_o    = mem_req_o && mem_gnt_i && sel_ls;
    if_rvalid_o = mem_rvalid_i && !empty && !head;
    ls_rvalid_o = mem_rvalid_i && !empty && head;
    if_rdata_o  = mem_rdata_i;
    ls_rdata_o  = mem_rdata_i;
  end

  // Owner FIFO: one bit per accepted transaction, 1 means the LSU owns the response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      owner_q <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel_ls;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!if_req_i) begin
      starve_cnt <= '0;
    end else if (accept && !sel_ls) begin
      starve_cnt <= '0;
    end else if (accept && sel_ls && starve_cnt != SC_MAX) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  // Sticky: a requester abandoning a locked request, or a response nobody is waiting for.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_o <= 1'b0;
    end else if (hold_drop || (mem_rvalid_i && empty)) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Testbench for imem_dmem_port_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model of arbitration, locking, starvation and response routing.
module tb_imem_dmem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = DATA_W / 8;
  localparam int MAX_OUT = 2;
  localparam int LIMIT   = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              ls_req_i;
  logic              ls_we_i;
  logic [BE_W-1:0]   ls_be_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              err_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  imem_dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  task automatic idle_inputs();
    if_req_i     = 1'b0;
    if_addr_i    = '0;
    ls_req_i     = 1'b0;
    ls_we_i      = 1'b0;
    ls_be_i      = '0;
    ls_addr_i    = '0;
    ls_wdata_i   = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n      = 1'b0;
    if_req_i     = 1'b1;
    ls_req_i     = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    @(negedge clock);
    #1;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_cmp++; if (if_gnt_o !== 1'b0 || ls_gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gnt: got if=%b ls=%b want 0 0", if_gnt_o, ls_gnt_o); end
    n_cmp++; if (if_rvalid_o !== 1'b0 || ls_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rvalid: got if=%b ls=%b want 0 0", if_rvalid_o, ls_rvalid_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", err_o); end
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    n_cmp++; if (err_o !== 1'b0 || mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle: got err=%b req=%b want 0 0", err_o, mem_req_o); end
  endtask

  task automatic test_fetch_only();
    @(negedge clock);
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0040;
    mem_gnt_i = 1'b1;
    #1;
    n_cmp++; if (if_gnt_o !== 1'b1 || ls_gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_gnt: got if=%b ls=%b want 1 0", if_gnt_o, ls_gnt_o); end
    n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin n_fail++; $display("[TB] FAIL fetch_mem: got req=%b addr=%h want 1 00000040", mem_req_o, mem_addr_o); end
    n_cmp++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_wdata_o !== '0) begin n_fail++; $display("[TB] FAIL fetch_attr: got we=%b be=%h wd=%h want 0 f 0", mem_we_o, mem_be_o, mem_wdata_o); end
    @(negedge clock);
    if_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0013;
    #1;
    n_cmp++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h13) begin n_fail++; $display("[TB] FAIL fetch_rsp: got v=%b d=%h want 1 00000013", if_rvalid_o, if_rdata_o); end
    n_cmp++; if (ls_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_rsp_ls: got %b want 0", ls_rvalid_o); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic exp_ls;
    logic prev_ls;
    @(negedge clock);
    if_req_i  = 1'b1;
    if_addr_i = 32'h80;
    ls_req_i  = 1'b1;
    ls_addr_i = 32'h180;
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_rvalid_i = (i > 0);
      mem_rdata_i  = $urandom;
      #1;
      exp_ls = ((i % 5) != 4);
      n_cmp++; if (ls_gnt_o !== exp_ls || if_gnt_o !== !exp_ls) begin n_fail++; $display("[TB] FAIL starve_gnt[%0d]: got ls=%b if=%b want ls=%b", i, ls_gnt_o, if_gnt_o, exp_ls); end
      if (i > 0) begin
        prev_ls = (((i - 1) % 5) != 4);
        n_cmp++; if (ls_rvalid_o !== prev_ls || if_rvalid_o !== !prev_ls) begin n_fail++; $display("[TB] FAIL starve_rsp[%0d]: got ls=%b if=%b want ls=%b", i, ls_rvalid_o, if_rvalid_o, prev_ls); end
      end
      @(negedge clock);
    end
    if_req_i     = 1'b0;
    ls_req_i     = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    n_cmp++; if (if_rvalid_o !== 1'b1 || ls_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL starve_drain: got if=%b ls=%b want 1 0", if_rvalid_o, ls_rvalid_o); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_hold_write();
    @(negedge clock);
    if_req_i   = 1'b1;
    if_addr_i  = 32'h200;
    ls_req_i   = 1'b1;
    ls_we_i    = 1'b1;
    ls_be_i    = 4'b0011;
    ls_addr_i  = 32'h100;
    ls_wdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = (i == 3);
      #1;
      n_cmp++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 || mem_addr_o !== 32'h100 || mem_wdata_o !== 32'hDEAD_BEEF) begin
        n_fail++; $display("[TB] FAIL hold_mem[%0d]: got req=%b we=%b be=%h addr=%h wd=%h want 1 1 3 00000100 deadbeef", i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
      end
      n_cmp++; if (ls_gnt_o !== (i == 3) || if_gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_gnt[%0d]: got ls=%b if=%b want ls=%b if=0", i, ls_gnt_o, if_gnt_o, (i == 3)); end
      @(negedge clock);
    end
    ls_req_i     = 1'b0;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    #1;
    n_cmp++; if (if_gnt_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_we_o !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_next_fetch: got gnt=%b addr=%h we=%b want 1 00000200 0", if_gnt_o, mem_addr_o, mem_we_o); end
    n_cmp++; if (ls_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_write_ack: got ls=%b if=%b want 1 0", ls_rvalid_o, if_rvalid_o); end
    @(negedge clock);
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b0;
    #1;
    n_cmp++; if (if_rvalid_o !== 1'b1 || ls_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_fetch_rsp: got if=%b ls=%b want 1 0", if_rvalid_o, ls_rvalid_o); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_full();
    @(negedge clock);
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    mem_gnt_i = 1'b1;
    #1;
    n_cmp++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL full_first: got %b want 1", if_gnt_o); end
    @(negedge clock);
    if_req_i  = 1'b0;
    ls_req_i  = 1'b1;
    ls_addr_i = 32'h300;
    #1;
    n_cmp++; if (ls_gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL full_second: got %b want 1", ls_gnt_o); end
    @(negedge clock);
    ls_req_i  = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h44;
    #1;
    n_cmp++; if (mem_req_o !== 1'b0 || if_gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL full_block: got req=%b gnt=%b want 0 0", mem_req_o, if_gnt_o); end
    @(negedge clock);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_0000;
    #1;
    n_cmp++; if (mem_req_o !== 1'b0 || if_gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL full_block_rvalid: got req=%b gnt=%b want 0 0", mem_req_o, if_gnt_o); end
    n_cmp++; if (if_rvalid_o !== 1'b1 || ls_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL full_rsp_first: got if=%b ls=%b want 1 0", if_rvalid_o, ls_rvalid_o); end
    @(negedge clock);
    mem_rdata_i = 32'h2222_0000;
    #1;
    n_cmp++; if (mem_req_o !== 1'b1 || if_gnt_o !== 1'b1 || mem_addr_o !== 32'h44) begin n_fail++; $display("[TB] FAIL full_resume: got req=%b gnt=%b addr=%h want 1 1 00000044", mem_req_o, if_gnt_o, mem_addr_o); end
    n_cmp++; if (ls_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0 || ls_rdata_o !== 32'h2222_0000) begin n_fail++; $display("[TB] FAIL full_rsp_second: got ls=%b if=%b d=%h want 1 0 22220000", ls_rvalid_o, if_rvalid_o, ls_rdata_o); end
    @(negedge clock);
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b0;
    #1;
    n_cmp++; if (if_rvalid_o !== 1'b1 || ls_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL full_rsp_third: got if=%b ls=%b want 1 0", if_rvalid_o, ls_rvalid_o); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_spurious_rvalid();
    @(negedge clock);
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL spurious_pre_err: got %b want 0", err_o); end
    mem_rvalid_i = 1'b1;
    #1;
    n_cmp++; if (if_rvalid_o !== 1'b0 || ls_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL spurious_rvalid: got if=%b ls=%b want 0 0", if_rvalid_o, ls_rvalid_o); end
    @(negedge clock);
    mem_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL spurious_err: got %b want 1", err_o); end
    repeat (3) @(negedge clock);
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL spurious_err_sticky: got %b want 1", err_o); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clock);
    do_reset();
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    mem_gnt_i = 1'b1;
    @(negedge clock);
    if_req_i  = 1'b0;
    ls_req_i  = 1'b1;
    ls_addr_i = 32'h400;
    mem_gnt_i = 1'b0;
    #1;
    n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h400) begin n_fail++; $display("[TB] FAIL midrst_setup: got req=%b addr=%h want 1 00000400", mem_req_o, mem_addr_o); end
    @(negedge clock);
    reset_n      = 1'b0;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    #1;
    n_cmp++; if (mem_req_o !== 1'b0 || if_gnt_o !== 1'b0 || ls_gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_req: got req=%b if=%b ls=%b want 0 0 0", mem_req_o, if_gnt_o, ls_gnt_o); end
    n_cmp++; if (if_rvalid_o !== 1'b0 || ls_rvalid_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_rsp: got if=%b ls=%b err=%b want 0 0 0", if_rvalid_o, ls_rvalid_o, err_o); end
    @(negedge clock);
    reset_n   = 1'b1;
    ls_req_i  = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h500;
    #1;
    n_cmp++; if (mem_req_o !== 1'b1 || if_gnt_o !== 1'b1 || mem_addr_o !== 32'h500) begin n_fail++; $display("[TB] FAIL midrst_idle: got req=%b gnt=%b addr=%h want 1 1 00000500", mem_req_o, if_gnt_o, mem_addr_o); end
    n_cmp++; if (if_rvalid_o !== 1'b0 || ls_rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_stale: got if=%b ls=%b want 0 0", if_rvalid_o, ls_rvalid_o); end
    @(negedge clock);
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b0;
    #1;
    n_cmp++; if (if_rvalid_o !== 1'b1 || ls_rvalid_o !== 1'b0 || err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_after: got if=%b ls=%b err=%b want 1 0 1", if_rvalid_o, ls_rvalid_o, err_o); end
    @(negedge clock);
    idle_inputs();
  endtask

  // Reference model: owner queue of pending responses, the requester a stalled issue is
  // locked to (0 none, 1 fetch, 2 LSU), and the count of consecutive fetch losses.
  task automatic test_random();
    bit                oq[$];
    int                lock = 0;
    int                losses = 0;
    bit                err_m = 1'b0;
    bit                prev_if_gnt = 1'b0;
    bit                prev_ls_gnt = 1'b0;
    int                pick;
    bit                dropped;
    bit                exp_req;
    bit                acc;
    bit                exp_if_rv;
    bit                exp_ls_rv;
    logic [ADDR_W-1:0] exp_addr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!if_req_i || prev_if_gnt) begin
        if_req_i  = ($urandom_range(0, 99) < 55);
        if_addr_i = $urandom;
      end
      if (!ls_req_i || prev_ls_gnt) begin
        ls_req_i   = ($urandom_range(0, 99) < 55);
        ls_we_i    = 1'($urandom);
        ls_be_i    = BE_W'($urandom);
        ls_addr_i  = $urandom;
        ls_wdata_i = $urandom;
      end
      mem_gnt_i    = ($urandom_range(0, 99) < 65);
      mem_rvalid_i = (oq.size() > 0) && ($urandom_range(0, 99) < 45);
      mem_rdata_i  = $urandom;

      dropped = 1'b0;
      pick    = 0;
      if (lock == 1) begin
        if (if_req_i) pick = 1; else dropped = 1'b1;
      end else if (lock == 2) begin
        if (ls_req_i) pick = 2; else dropped = 1'b1;
      end else if (if_req_i && ls_req_i) begin
        pick = (losses >= LIMIT) ? 1 : 2;
      end else if (ls_req_i) begin
        pick = 2;
      end else if (if_req_i) begin
        pick = 1;
      end
      exp_req   = (pick != 0) && (oq.size() < MAX_OUT);
      acc       = exp_req && mem_gnt_i;
      exp_if_rv = mem_rvalid_i && (oq.size() > 0) && (oq[0] == 1'b0);
      exp_ls_rv = mem_rvalid_i && (oq.size() > 0) && (oq[0] == 1'b1);
      exp_addr  = (pick == 2) ? ls_addr_i : if_addr_i;

      #1;
      n_cmp++; if (mem_req_o !== exp_req) begin n_fail++; $display("[TB] FAIL rand_req[%0d]: got %b want %b", c, mem_req_o, exp_req); end
      if (exp_req) begin
        n_cmp++; if (mem_addr_o !== exp_addr) begin n_fail++; $display("[TB] FAIL rand_addr[%0d]: got %h want %h", c, mem_addr_o, exp_addr); end
        if (pick == 2) begin
          n_cmp++; if (mem_we_o !== ls_we_i || mem_be_o !== ls_be_i || mem_wdata_o !== ls_wdata_i) begin
            n_fail++; $display("[TB] FAIL rand_ls_attr[%0d]: got we=%b be=%h wd=%h want %b %h %h", c, mem_we_o, mem_be_o, mem_wdata_o, ls_we_i, ls_be_i, ls_wdata_i);
          end
        end else begin
          n_cmp++; if (mem_we_o !== 1'b0 || mem_be_o !== {BE_W{1'b1}} || mem_wdata_o !== '0) begin
            n_fail++; $display("[TB] FAIL rand_if_attr[%0d]: got we=%b be=%h wd=%h want 0 f 0", c, mem_we_o, mem_be_o, mem_wdata_o);
          end
        end
      end
      n_cmp++; if (if_gnt_o !== (acc && pick == 1) || ls_gnt_o !== (acc && pick == 2)) begin
        n_fail++; $display("[TB] FAIL rand_gnt[%0d]: got if=%b ls=%b want if=%b ls=%b", c, if_gnt_o, ls_gnt_o, (acc && pick == 1), (acc && pick == 2));
      end
      n_cmp++; if (if_rvalid_o !== exp_if_rv || ls_rvalid_o !== exp_ls_rv) begin
        n_fail++; $display("[TB] FAIL rand_rvalid[%0d]: got if=%b ls=%b want if=%b ls=%b", c, if_rvalid_o, ls_rvalid_o, exp_if_rv, exp_ls_rv);
      end
      if (exp_if_rv || exp_ls_rv) begin
        n_cmp++; if ((exp_if_rv ? if_rdata_o : ls_rdata_o) !== mem_rdata_i) begin
          n_fail++; $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", c, (exp_if_rv ? if_rdata_o : ls_rdata_o), mem_rdata_i);
        end
      end
      n_cmp++; if (err_o !== err_m) begin n_fail++; $display("[TB] FAIL rand_err[%0d]: got %b want %b", c, err_o, err_m); end

      if (mem_rvalid_i) begin
        if (oq.size() > 0) void'(oq.pop_front());
        else err_m = 1'b1;
      end
      if (dropped) err_m = 1'b1;
      if (acc) oq.push_back(pick == 2);
      lock = (acc || dropped) ? 0 : pick;
      if (!if_req_i || (acc && pick == 1)) losses = 0;
      else if (acc && pick == 2 && losses < LIMIT) losses++;
      prev_if_gnt = acc && (pick == 1);
      prev_ls_gnt = acc && (pick == 2);
      @(negedge clock);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    test_reset();
    test_fetch_only();
    test_starvation();
    test_hold_write();
    test_full();
    test_spurious_rvalid();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
